// File: rtl/divider_multimode.sv
// divider_multimode: iterative DIV/DIVU/REM/REMU divider with abort, status flags and start/ready/valid handshake.
module divider_multimode #(
   parameter int DIV_SIZE       = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [1:0]          op,
   input  logic [DIV_SIZE-1:0] numerator,
   input  logic [DIV_SIZE-1:0] denominator,
   input  logic                kill,
   input  logic                ready_i,
   output logic                ready_o,
   output logic                valid,
   output logic [DIV_SIZE-1:0] quotient,
   output logic [DIV_SIZE-1:0] remainder,
   output logic [DIV_SIZE-1:0] result,
   output logic                div_by_zero,
   output logic                overflow
);
   localparam int N  = DIV_SIZE / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);
   localparam logic [DIV_SIZE-1:0] MIN = {1'b1, {(DIV_SIZE-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic [DIV_SIZE-1:0] r_quo, r_rem, r_den, w_quo, w_rem, w_q_fix, w_r_fix, w_abs_n, w_abs_d;
   logic [DIV_SIZE-1:0] r_quotient, r_remainder, r_result;
   logic [DIV_SIZE:0] w_t;
   logic r_neg_q, r_neg_r, r_op1, r_dbz, r_ovf;
   logic w_signed, w_zero, w_ovf;
   assign w_signed = !op[0];
   assign w_zero   = denominator == '0;
   assign w_ovf    = w_signed && numerator == MIN && denominator == '1;
   assign w_abs_n  = (w_signed && numerator[DIV_SIZE-1]) ? -numerator : numerator;
   assign w_abs_d  = (w_signed && denominator[DIV_SIZE-1]) ? -denominator : denominator;
   assign w_q_fix  = r_neg_q ? -r_quo : r_quo;
   assign w_r_fix  = r_neg_r ? -r_rem : r_rem;
   // r_quo shifts dividend bits out of the top while quotient bits enter at the bottom
   always_comb begin
      w_rem = r_rem;
      w_quo = r_quo;
      w_t   = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         w_t   = {w_rem, w_quo[DIV_SIZE-1]};
         w_quo = {w_quo[DIV_SIZE-2:0], w_t >= {1'b0, r_den}};
         w_t   = w_quo[0] ? w_t - {1'b0, r_den} : w_t;
         w_rem = w_t[DIV_SIZE-1:0];
      end
   end
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = start ? ((w_zero || w_ovf) ? DONE : CALC) : IDLE;
         CALC:    w_next = (r_cnt == CW'(N - 1)) ? FIX : CALC;
         FIX:     w_next = DONE;
         default: w_next = ready_i ? IDLE : DONE;
      endcase
      if (kill) w_next = IDLE;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt <= '0;
         r_quo <= '0;
         r_rem <= '0;
         r_den <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_op1 <= 1'b0;
         r_dbz <= 1'b0;
         r_ovf <= 1'b0;
         r_quotient <= '0;
         r_remainder <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_next;
         if (kill) begin
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
         end else begin
            unique case (r_state)
               IDLE: if (start) begin
                  r_op1 <= op[1];
                  r_neg_q <= w_signed && (numerator[DIV_SIZE-1] ^ denominator[DIV_SIZE-1]);
                  r_neg_r <= w_signed && numerator[DIV_SIZE-1];
                  r_dbz <= w_zero;
                  r_ovf <= w_ovf && !w_zero;
                  r_cnt <= '0;
                  r_rem <= '0;
                  r_quo <= w_abs_n;
                  r_den <= w_abs_d;
                  if (w_zero) begin
                     r_quotient <= '1;
                     r_remainder <= numerator;
                     r_result <= op[1] ? numerator : '1;
                  end else if (w_ovf) begin
                     r_quotient <= MIN;
                     r_remainder <= '0;
                     r_result <= op[1] ? '0 : MIN;
                  end
               end
               CALC: begin
                  r_rem <= w_rem;
                  r_quo <= w_quo;
                  r_cnt <= r_cnt + 1'b1;
               end
               FIX: begin
                  r_quotient <= w_q_fix;
                  r_remainder <= w_r_fix;
                  r_result <= r_op1 ? w_r_fix : w_q_fix;
               end
               default: ;
            endcase
         end
      end
   end
   assign ready_o     = r_state == IDLE && !reset;
   assign valid       = r_state == DONE;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign result      = r_result;
   assign div_by_zero = r_dbz;
   assign overflow    = r_ovf;
endmodule
